// File: rtl/vuprs_adc_s_axi_regs.sv
// AXI4-Lite slave exposing four 32-bit R/W registers.
// Independent write (AW/W in any order) and read FSMs; per-register write strobes.
module vuprs_adc_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_o,
  output logic [3:0]                        wr_pulse_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t              wstate_q, wstate_d;
  rstate_t              rstate_q, rstate_d;
  logic [3:0][DW-1:0]   regs_q, regs_d;
  logic                 aw_lat_q, aw_lat_d;
  logic                 w_lat_q, w_lat_d;
  logic [1:0]           awsel_q, awsel_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [NB-1:0]        wstrb_q, wstrb_d;
  logic [3:0]           pulse_q, pulse_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 ready_en_q;

  // Readies stay low until the first clock edge out of reset.
  logic awready, wready, arready;
  assign awready = ready_en_q && (wstate_q == W_IDLE) && !aw_lat_q;
  assign wready  = ready_en_q && (wstate_q == W_IDLE) && !w_lat_q;
  assign arready = ready_en_q && (rstate_q == R_IDLE);

  always_comb begin
    wstate_d = wstate_q;
    regs_d   = regs_q;
    aw_lat_d = aw_lat_q;
    w_lat_d  = w_lat_q;
    awsel_d  = awsel_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    pulse_d  = '0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_lat_q && w_lat_q) begin
          for (int b = 0; b < NB; b++) begin
            if (wstrb_q[b]) regs_d[awsel_q][8*b +: 8] = wdata_q[8*b +: 8];
          end
          pulse_d[awsel_q] = 1'b1;
          aw_lat_d = 1'b0;
          w_lat_d  = 1'b0;
          wstate_d = W_RESP;
        end else begin
          if (awready && S_AXI_AWVALID) begin
            aw_lat_d = 1'b1;
            awsel_d  = S_AXI_AWADDR[3:2];
          end
          if (wready && S_AXI_WVALID) begin
            w_lat_d = 1'b1;
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read samples regs_q, so a commit at the same edge is not visible yet.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (arready && S_AXI_ARVALID) begin
          rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      regs_q     <= '0;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      awsel_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      pulse_q    <= '0;
      rdata_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      regs_q     <= regs_d;
      aw_lat_q   <= aw_lat_d;
      w_lat_q    <= w_lat_d;
      awsel_q    <= awsel_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      pulse_q    <= pulse_d;
      rdata_q    <= rdata_d;
      ready_en_q <= 1'b1;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_o         = regs_q;
  assign wr_pulse_o    = pulse_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: doc/vuprs_adc_s_axi_regs.md
VUPRS_ADC_S_AXI_REGS -- requirements
Module: vuprs_adc_s_axi_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4: byte address width covering 4 word registers.
REQ-003 S_AXI_ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 S_AXI_ARESETN  in  1  reset, synchronous and active-low.
REQ-005 S_AXI_AWADDR/S_AXI_AWPROT/S_AXI_AWVALID  in  4/3/1  write address channel; AWPROT ignored.
REQ-006 S_AXI_AWREADY  out  1  write address accept.
REQ-007 S_AXI_WDATA/S_AXI_WSTRB/S_AXI_WVALID  in  32/4/1  write data channel.
REQ-008 S_AXI_WREADY  out  1  write data accept.
REQ-009 S_AXI_BRESP/S_AXI_BVALID  out  2/1  write response; S_AXI_BREADY in 1.
REQ-010 S_AXI_ARADDR/S_AXI_ARPROT/S_AXI_ARVALID  in  4/3/1  read address; ARPROT ignored; S_AXI_ARREADY out 1.
REQ-011 S_AXI_RDATA/S_AXI_RRESP/S_AXI_RVALID  out  32/2/1  read data; S_AXI_RREADY in 1.
REQ-012 reg_o  out  128  current contents of reg3..reg0, reg k at bits [32k+31:32k].
REQ-013 wr_pulse_o  out  4  one-cycle strobe, bit k when reg k is written.

Function
REQ-014 Four 32-bit R/W registers reg0..reg3 at byte offsets 0x0/0x4/0x8/0xC, selected by address bits [3:2]; bits [1:0] ignored.
REQ-015 Write FSM states W_IDLE, W_RESP; read FSM states R_IDLE, R_DATA; both FSMs fully independent.
REQ-016 In W_IDLE: AWREADY=1 while no address latched; WREADY=1 while no data latched; AW and W are accepted in any order, or in the same cycle.
REQ-017 Cycle N in which the second of AW/W is latched: at edge N+1 the register is updated, BVALID=1, wr_pulse_o[k]=1 for exactly that cycle, FSM enters W_RESP.
REQ-018 Byte-lane write: lane b is updated only when WSTRB[b]=1; WSTRB=0 still completes the handshake and pulses wr_pulse_o[k].
REQ-019 In W_RESP: AWREADY=WREADY=0; BVALID held until BVALID&BREADY; then return to W_IDLE, with readies high the next cycle.
REQ-020 BRESP=2'b00 and RRESP=2'b00 always; no error responses.
REQ-021 In R_IDLE: ARREADY=1; on ARVALID&ARREADY at edge N, RDATA captures the selected register value present before edge N; RVALID=1 from N+1; ARREADY=0.
REQ-022 In R_DATA: RDATA/RVALID held stable until RVALID&RREADY; then R_IDLE and ARREADY=1 the next cycle.
REQ-023 Simultaneous read accept and write commit on the same register at the same edge: the read returns the old value.
REQ-024 At most one outstanding write and one outstanding read; no interleaving or reordering is required.
REQ-025 reg_o reflects register contents combinationally from the flops, with no extra latency.

Reset
REQ-026 S_AXI_ARESETN=0 sampled at an edge sets reg0..reg3=0, all READY/VALID=0, RDATA=0, BRESP=RRESP=0, wr_pulse_o=0, both FSMs idle, and clears any latched AW/W.
REQ-027 Reset mid-transaction abandons that transaction: no BVALID/RVALID for it after reset release.
REQ-028 AWREADY, WREADY and ARREADY go to 1 on the first edge with S_AXI_ARESETN=1.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with WSTRB=0xF, then read each -> RDATA 0x1..0x4, RRESP=0, BRESP=0, reg_o=0x00000004_00000003_00000002_00000001.
REQ-030 AW to 0x8 three cycles before W=0xDEADBEEF -> WREADY stays 1, BVALID and wr_pulse_o=4'b0100 one cycle after W accepted, reg2=0xDEADBEEF.
REQ-031 With reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0010 -> reg0=0x1122CC44.
REQ-032 BREADY held low 5 cycles -> BVALID stays 1, AWREADY=WREADY=0 throughout, a queued second write is accepted only after the B handshake.
REQ-033 With reg1=0x5, read of 0x4 accepted in the same cycle as the commit of a write of 0x9 to 0x4 -> RDATA=0x5; a following read returns 0x9.
REQ-034 S_AXI_ARESETN low 1 cycle while BVALID=1 and RVALID=1 -> both 0 next cycle, reg_o=0, all READYs 1 after release, with no stale response.
